// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, monitor states and the wide absolute-difference helper
package fir_pkg;

  localparam int NB    = 12;
  localparam int N     = 10;
  localparam int DEPTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // One extra bit keeps |a-b| exact even for full-scale opposite-sign operands.
  function automatic logic [NB:0] abs_diff(input logic signed [NB-1:0] a,
                                           input logic signed [NB-1:0] b);
    logic signed [NB:0] d;
    logic [NB:0]        r;
    d = {a[NB-1], a} - {b[NB-1], b};
    r = d;
    if (d[NB]) r = -d;
    return r;
  endfunction

endpackage

// File: rtl/fir_exp_mem.sv
// rtl/fir_exp_mem.sv - expected-sample table, one write port and one asynchronous read port
module fir_exp_mem #(
  parameter int NB    = 12,
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [NB-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [NB-1:0] rd_data
);
  import fir_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [NB-1:0] mem_q [DEPTH];

  // The table is deliberately left without reset so a monitor reset keeps it.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr <= LAST_ADDR)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr <= LAST_ADDR) rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/fir_out_monitor.sv
// rtl/fir_out_monitor.sv - checks the filter output stream against a tolerance-based expected table
module fir_out_monitor #(
  parameter int NB    = fir_pkg::NB,
  parameter int DEPTH = fir_pkg::DEPTH,
  parameter int AW    = 5,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] DOUT,
  input  logic          VOUT,
  input  logic          EXP_WE,
  input  logic [AW-1:0] EXP_ADDR,
  input  logic [NB-1:0] EXP_DATA,
  input  logic [NB-1:0] TOL,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [CW-1:0] ERR_CNT,
  output logic [AW-1:0] FIRST_ERR_IDX,
  output logic          FIRST_ERR_VLD
);
  import fir_pkg::*;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] ERR_MAX  = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_idx_q, first_idx_d;
  logic          first_vld_q, first_vld_d;
  logic          pass_q, pass_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          wr_en;
  logic [NB-1:0] exp_rd;
  logic [NB:0]   adiff;
  logic          mism;

  assign wr_en = EXP_WE && (state_q != ST_RUN);

  fir_exp_mem #(
    .NB   (NB),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_exp_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(EXP_ADDR),
    .wr_data(EXP_DATA),
    .rd_addr(idx_q),
    .rd_data(exp_rd)
  );

  assign adiff = abs_diff(DOUT, exp_rd);
  assign mism  = adiff > {1'b0, TOL};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d     = ST_RUN;
          idx_d       = '0;
          err_cnt_d   = '0;
          first_idx_d = '0;
          first_vld_d = 1'b0;
          pass_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (VOUT) begin
          if (mism) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
            if (!first_vld_q) begin
              first_idx_d = idx_q;
              first_vld_d = 1'b1;
            end
          end
          // idx parks on the last entry so the read port never leaves the table.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            pass_d  = (err_cnt_d == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PASS          = pass_q;
  assign ERR_CNT       = err_cnt_q;
  assign FIRST_ERR_IDX = first_idx_q;
  assign FIRST_ERR_VLD = first_vld_q;

endmodule

// File: tb/tb_fir_out_monitor.sv
// tb/tb_fir_out_monitor.sv - table-driven and scoreboard bench for fir_out_monitor
module tb_fir_out_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] dout = '0;
  logic        vout = 1'b0;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_addr = '0;
  logic [11:0] exp_data = '0;
  logic [11:0] tol = '0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;

  logic        busy_a, done_a, pass_a, fvld_a;
  logic [7:0]  err_a;
  logic [2:0]  fidx_a;
  logic        busy_b, done_b, pass_b, fvld_b;
  logic [1:0]  err_b;
  logic [2:0]  fidx_b;

  fir_out_monitor #(.NB(12), .DEPTH(5), .AW(3), .CW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .DOUT(dout), .VOUT(vout), .EXP_WE(exp_we),
    .EXP_ADDR(exp_addr), .EXP_DATA(exp_data), .TOL(tol), .START(start_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a),
    .FIRST_ERR_IDX(fidx_a), .FIRST_ERR_VLD(fvld_a)
  );

  fir_out_monitor #(.NB(12), .DEPTH(6), .AW(3), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .DOUT(dout), .VOUT(vout), .EXP_WE(exp_we),
    .EXP_ADDR(exp_addr), .EXP_DATA(exp_data), .TOL(tol), .START(start_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b),
    .FIRST_ERR_IDX(fidx_b), .FIRST_ERR_VLD(fvld_b)
  );

  always #5 clk = ~clk;

  typedef logic [4:0][11:0] v5_t;
  typedef struct packed {
    v5_t         tab;
    v5_t         d;
    v5_t         gap;
    logic [11:0] tol;
    int          x_err;
    int          x_fidx;
    int          x_vld;
    int          x_pass;
  } run_t;

  typedef struct packed {
    logic [31:0] busy, done, pass, err, fidx, fvld;
  } obs_t;

  typedef struct {
    int err;
    int vld;
    int fidx;
  } sb_t;

  int  checks = 0;
  int  failures = 0;
  int  m_err, m_vld, m_fidx;
  sb_t sb_q[$];
  run_t runs[6];
  int  base[5];

  function automatic v5_t pack5(input int a, input int b, input int c, input int d, input int e);
    v5_t v;
    v[0] = 12'(a); v[1] = 12'(b); v[2] = 12'(c); v[3] = 12'(d); v[4] = 12'(e);
    return v;
  endfunction

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{32'(busy_a), 32'(done_a), 32'(pass_a), 32'(err_a), 32'(fidx_a), 32'(fvld_a)};
    else          o = '{32'(busy_b), 32'(done_b), 32'(pass_b), 32'(err_b), 32'(fidx_b), 32'(fvld_b)};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    exp_we = 1'b1; exp_addr = 3'(addr); exp_data = 12'(data);
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  task automatic start_run(input int sel);
    obs_t o;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    m_err = 0; m_vld = 0; m_fidx = 0;
    o = obs(sel);
    chk("start_busy", o.busy, 1);
    chk("start_done", o.done, 0);
    chk("start_err", o.err, 0);
    chk("start_vld", o.fvld, 0);
    chk("start_pass", o.pass, 0);
  endtask

  task automatic gap_cycle(input int sel);
    obs_t o;
    @(negedge clk);
    o = obs(sel);
    chk("gap_busy", o.busy, 1);
    chk("gap_done", o.done, 0);
  endtask

  // Drives one valid sample at the current negedge; the model result is queued and
  // popped once the accepting edge has passed.
  task automatic send(input int sel, input int idx, input int d, input int e, input int tl,
                      input int errmax, input bit last);
    sb_t  s;
    obs_t o;
    int   ad;
    dout = 12'(d); vout = 1'b1;
    ad = d - e;
    if (ad < 0) ad = -ad;
    if (ad > tl) begin
      if (m_err < errmax) m_err++;
      if (m_vld == 0) begin m_vld = 1; m_fidx = idx; end
    end
    s.err = m_err; s.vld = m_vld; s.fidx = m_fidx;
    sb_q.push_back(s);
    @(negedge clk);
    vout = 1'b0;
    o = obs(sel);
    s = sb_q.pop_front();
    chk("err_cnt", o.err, s.err);
    chk("first_vld", o.fvld, s.vld);
    if (s.vld != 0) chk("first_idx", o.fidx, s.fidx);
    chk("done", o.done, last);
    chk("busy", o.busy, !last);
    if (last) chk("pass", o.pass, (s.err == 0));
  endtask

  task automatic send_base(input int sel);
    for (int i = 0; i < 5; i++) send(sel, i, base[i], base[i], 0, 255, i == 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    obs_t o;
    base = '{0, 158, 0, 414, 0};
    runs[0] = '{pack5(0,158,0,414,0), pack5(0,158,0,414,0), pack5(0,0,0,0,0), 12'd0, 0, 0, 0, 1};
    runs[1] = '{pack5(0,158,0,414,0), pack5(0,158,1,414,-3), pack5(0,0,0,0,0), 12'd1, 1, 4, 1, 0};
    runs[2] = '{pack5(2047,-2048,5,5,5), pack5(-2048,2047,5,6,4), pack5(0,0,0,0,0), 12'd2047, 2, 0, 1, 0};
    runs[3] = '{pack5(1,2,3,4,5), pack5(1,2,3,4,5), pack5(0,3,1,2,0), 12'd0, 0, 0, 0, 1};
    runs[4] = '{pack5(2047,0,0,0,0), pack5(-2048,0,0,0,0), pack5(0,0,0,0,0), 12'd4095, 0, 0, 0, 1};
    runs[5] = '{pack5(-1,-1,-1,-1,-1), pack5(-1,-1,10,-1,-1), pack5(0,1,0,0,2), 12'd10, 1, 2, 1, 0};

    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      chk("rst_busy", o.busy, 0); chk("rst_done", o.done, 0); chk("rst_pass", o.pass, 0);
      chk("rst_err", o.err, 0); chk("rst_fidx", o.fidx, 0); chk("rst_vld", o.fvld, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 5; i++) wr(i, int'($signed(runs[r].tab[i])));
      tol = runs[r].tol;
      start_run(0);
      for (int i = 0; i < 5; i++) begin
        for (int g = 0; g < int'(runs[r].gap[i]); g++) gap_cycle(0);
        send(0, i, int'($signed(runs[r].d[i])), int'($signed(runs[r].tab[i])),
             int'(runs[r].tol), 255, i == 4);
      end
      o = obs(0);
      chk("run_err", o.err, runs[r].x_err);
      chk("run_vld", o.fvld, runs[r].x_vld);
      chk("run_pass", o.pass, runs[r].x_pass);
      if (runs[r].x_vld != 0) chk("run_fidx", o.fidx, runs[r].x_fidx);
    end

    // Write during RUN and START during RUN are both ignored.
    for (int i = 0; i < 5; i++) wr(i, base[i]);
    tol = '0;
    start_run(0);
    send(0, 0, 7, 0, 0, 255, 1'b0);
    send(0, 1, 158, 158, 0, 255, 1'b0);
    start_a = 1'b1; exp_we = 1'b1; exp_addr = 3'd2; exp_data = 12'd999;
    @(negedge clk);
    start_a = 1'b0; exp_we = 1'b0;
    o = obs(0);
    chk("norestart_busy", o.busy, 1);
    chk("norestart_err", o.err, 1);
    send(0, 2, 0, 0, 0, 255, 1'b0);
    send(0, 3, 414, 414, 0, 255, 1'b0);
    send(0, 4, 0, 0, 0, 255, 1'b1);

    // START from DONE clears results; table entry 2 kept its old value.
    start_run(0);
    send_base(0);

    // Asynchronous reset mid-run, then a run on the retained table.
    start_run(0);
    send(0, 0, 0, 0, 0, 255, 1'b0);
    send(0, 1, 5, 158, 0, 255, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    o = obs(0);
    chk("arst_busy", o.busy, 0); chk("arst_done", o.done, 0); chk("arst_pass", o.pass, 0);
    chk("arst_err", o.err, 0); chk("arst_fidx", o.fidx, 0); chk("arst_vld", o.fvld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(0);
    send_base(0);

    // START and a table write in the same cycle: the new entry 0 is used immediately.
    start_a = 1'b1; exp_we = 1'b1; exp_addr = 3'd0; exp_data = 12'd33;
    @(negedge clk);
    start_a = 1'b0; exp_we = 1'b0;
    m_err = 0; m_vld = 0; m_fidx = 0;
    chk("startwr_busy", busy_a, 1);
    send(0, 0, 33, 33, 0, 255, 1'b0);
    for (int i = 1; i < 5; i++) send(0, i, base[i], base[i], 0, 255, i == 4);

    // Saturating 2-bit error counter on the six-entry instance.
    chk("b_idle_busy", busy_b, 0);
    chk("b_idle_err", err_b, 0);
    for (int i = 0; i < 6; i++) wr(i, 0);
    start_run(1);
    for (int i = 0; i < 6; i++) send(1, i, 100, 0, 0, 3, i == 5);
    chk("sat_err", err_b, 3);
    chk("sat_fidx", fidx_b, 0);
    chk("a_hold_done", done_a, 1);
    chk("a_hold_pass", pass_a, 1);
    chk("a_hold_err", err_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_out_monitor.md
Name: fir_out_monitor

Overview:
Synthesizable consumer for the FIR output stream (DOUT/VOUT) of the lab01 filter. It takes one output sample per VOUT cycle, compares it with a programmable table of expected samples using a tolerance, and reports pass/fail, the error count and the index of the first mismatch. It sits downstream of Filter. The same sample-valid protocol drives the filter input, and this block is the receiving end of the output side.

Parameters:
NB, 12, sample width in bits (two's complement), equal to the filter Nb
DEPTH, 20, number of expected samples per run
AW, 5, table address / sample index width, must satisfy 2^AW >= DEPTH
CW, 8, error counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
DOUT  in  NB  filter output sample, signed
VOUT  in  1  DOUT valid, one sample per cycle when high
EXP_WE  in  1  expected-table write enable
EXP_ADDR  in  AW  expected-table write address
EXP_DATA  in  NB  expected sample, signed
TOL  in  NB  allowed absolute error, unsigned
START  in  1  one-cycle start/restart pulse
BUSY  out  1  high in RUN
DONE  out  1  high in DONE
PASS  out  1  valid when DONE: 1 if ERR_CNT==0
ERR_CNT  out  CW  mismatch count, saturating
FIRST_ERR_IDX  out  AW  index of the first mismatching sample
FIRST_ERR_VLD  out  1  FIRST_ERR_IDX is meaningful

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR_IDX=0, FIRST_ERR_VLD=0.
- The expected table has no reset. Its contents are undefined until written.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on START.
  - RUN -> DONE when the DEPTH-th valid sample is accepted.
  - DONE -> RUN on START.
  - No other transitions.
- Entering RUN, on the START edge: idx, ERR_CNT, FIRST_ERR_* and PASS are cleared. BUSY=1 from the next cycle.
- Table writes: on a clk edge with EXP_WE=1, table[EXP_ADDR] <= EXP_DATA.
  - Accepted in IDLE and DONE only. Ignored in RUN.
  - EXP_ADDR >= DEPTH is ignored.
- Sample acceptance: only in RUN, on any cycle with VOUT=1. VOUT=0 cycles are gaps and do not advance idx.
- Compare:
  - diff = DOUT - table[idx], computed sign-extended to NB+1 bits.
  - |diff| is computed in NB+1 bits with no overflow.
  - Mismatch if |diff| > zero-extended TOL.
- On a mismatch: ERR_CNT increments and saturates at 2^CW-1. If FIRST_ERR_VLD=0, FIRST_ERR_IDX <= idx and FIRST_ERR_VLD <= 1 in the same cycle.
- idx increments per accepted sample. No wrap: acceptance stops at DEPTH.
- Latency: the result registers update on the clock edge that accepts the sample. DONE=1 and BUSY=0 on the cycle after the last accepted sample. PASS is registered together with DONE and already reflects the last sample.
- Outputs hold in DONE until the next START or reset.
- VOUT in IDLE or DONE is ignored.
- START while in RUN is ignored.
- START and EXP_WE in the same cycle (IDLE/DONE): the write completes and the run starts. The written value is visible for idx=0 on the next cycle.
- Reset mid-RUN aborts the run. All outputs return to reset values and the table is retained.
- All outputs are registered.

Decomposition:
- Package fir_pkg:
  - NB default 12
  - filter order N default 10
  - DEPTH default 20
  - state enum {IDLE, RUN, DONE}
  - a function computing the NB+1-bit absolute difference
- One sub-module, fir_exp_mem: DEPTH x NB register array with one write port and one combinational read port (read address idx).
- fir_out_monitor holds the FSM, counters and compare logic.

Test Plan:
- Load table with 0,158,0,414,0 (DEPTH=5, TOL=0), START, drive the same values with VOUT=1 every cycle -> DONE five cycles after the first sample, PASS=1, ERR_CNT=0, FIRST_ERR_VLD=0.
- Same table, drive 0,158,1,414,-3 with TOL=1 -> ERR_CNT=1, FIRST_ERR_IDX=4, PASS=0. Extreme operands: table 2047 with DOUT -2048 -> mismatch, no overflow.
- VOUT gaps: 5 samples spread with 0-3 idle cycles between them -> DONE only after the 5th valid sample; BUSY high throughout.
- Error counter saturation with CW=2: 6 mismatching samples -> ERR_CNT=3.
- Boundaries:
  - EXP_WE during RUN to idx 2 with a new value -> ignored; the compare still uses the old value.
  - START in RUN -> no restart.
  - START in DONE -> counters cleared and a second run works.
- rst_n=0 asynchronously after 2 accepted samples -> outputs at reset values immediately. After START, the table content loaded before reset is used and the run passes.
